// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the data-memory arbiter: read-owner encoding,
// default bus widths and the starvation counter width.
package data_mem_pkg;
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_IO   = 2'd2
   } own_e;

   localparam int ADDR_W_DEF   = 16;
   localparam int DATA_W_DEF   = 16;
   localparam int STARVE_CNT_W = 4;
endpackage

// File: rtl/data_mem_arbiter_starve_counter.sv
// Saturating up-counter with synchronous clear; counts consecutive cycles the
// I/O requester has been denied.
module starve_counter #(
   parameter int MAX = 4,
   parameter int W   = 4
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_cnt
);
   localparam logic [W-1:0] LIM = W'(MAX);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                  r_cnt <= '0;
      else if (i_clr)                r_cnt <= '0;
      else if (i_inc && r_cnt < LIM) r_cnt <= r_cnt + 1'b1;
   end

   assign o_cnt = r_cnt;
endmodule

// File: rtl/data_mem_arbiter.sv
// Single-port data RAM arbiter between the CPU memory stage and a secondary
// I/O requester; CPU has priority until I/O has been denied STARVE_MAX cycles.
module data_mem_arbiter
   import data_mem_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_halt,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   input  logic              io_req,
   input  logic              io_we,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] io_wdata,
   output logic              io_gnt,
   output logic [DATA_W-1:0] io_rdata,
   output logic              io_rvalid,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);
   localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

   logic                    w_cpu_v;
   logic                    w_cpu_gnt;
   logic                    w_io_gnt;
   logic [STARVE_CNT_W-1:0] w_starve_cnt;
   own_e                    w_rd_own_nxt;
   own_e                    r_rd_own;

   assign w_cpu_v   = cpu_req & ~cpu_halt;
   assign w_cpu_gnt = w_cpu_v && (w_starve_cnt < STARVE_LIM);
   assign w_io_gnt  = ~w_cpu_gnt & io_req;

   assign cpu_stall = w_cpu_v & w_io_gnt;
   assign io_gnt    = w_io_gnt;

   starve_counter #(
      .MAX (STARVE_MAX),
      .W   (STARVE_CNT_W)
   ) u_starve (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_inc   (io_req & ~w_io_gnt),
      .i_clr   (w_io_gnt | ~io_req),
      .o_cnt   (w_starve_cnt)
   );

   // Grants still resolve during reset, but the RAM is never enabled then.
   always_comb begin
      ram_en       = 1'b0;
      ram_we       = 1'b0;
      ram_addr     = '0;
      ram_wdata    = '0;
      w_rd_own_nxt = OWN_NONE;
      if (w_cpu_gnt) begin
         ram_en    = rst_n;
         ram_we    = cpu_we;
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
         if (!cpu_we) w_rd_own_nxt = OWN_CPU;
      end else if (w_io_gnt) begin
         ram_en    = rst_n;
         ram_we    = io_we;
         ram_addr  = io_addr;
         ram_wdata = io_wdata;
         if (!io_we) w_rd_own_nxt = OWN_IO;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rd_own <= OWN_NONE;
      else        r_rd_own <= w_rd_own_nxt;
   end

   assign cpu_rvalid = (r_rd_own == OWN_CPU);
   assign io_rvalid  = (r_rd_own == OWN_IO);
   assign cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
   assign io_rdata   = io_rvalid  ? ram_rdata : '0;
endmodule
